node_io: RTL and testbench

NODE_IO -- requirements
Module: node_io

---
 rtl/node_io.sv | 184 ++++++++++++++++++
 tb/tb_node_io.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/node_io.sv
// node_io: one node's handshake bridge between its read/write requests and four neighbour links.
// Latency: NIL/ACC/unresolved-LAST done one cycle after the request is seen; neighbour ops done one cycle after the transfer.
// Backpressure: holds in RD_WAIT/WR_WAIT until a neighbour handshakes or the request is withdrawn.
// Optional feature: NODE_IO_LAST_PORT_EN enables the LAST source/destination (remembers the last ANY winner).

package types_pkg;
    localparam int WORD_SIZE = 11;

    // Link index of each neighbour, also the bit index into the 4-wide handshake buses.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } direction_t;

    // Directions share their encoding with direction_t so the low two bits select the link.
    typedef enum logic [2:0] {
        SRC_UP    = 3'd0,
        SRC_DOWN  = 3'd1,
        SRC_LEFT  = 3'd2,
        SRC_RIGHT = 3'd3,
        SRC_ANY   = 3'd4,
        SRC_NIL   = 3'd5,
        SRC_ACC   = 3'd6,
        SRC_LAST  = 3'd7
    } src_t;
endpackage

module node_io #(
    parameter int WORD_SIZE = types_pkg::WORD_SIZE
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      rd_req,
    input  logic [2:0]                rd_src,
    output logic [WORD_SIZE-1:0]      rd_data,
    output logic                      rd_done,
    input  logic                      wr_req,
    input  logic [2:0]                wr_dst,
    input  logic [WORD_SIZE-1:0]      wr_data,
    output logic                      wr_done,
    input  logic [3:0]                in_valid,
    input  logic [3:0][WORD_SIZE-1:0] in_data,
    output logic [3:0]                in_ready,
    output logic [3:0]                out_valid,
    output logic [WORD_SIZE-1:0]      out_data,
    input  logic [3:0]                out_ready
);
    import types_pkg::*;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_src;
    logic [WORD_SIZE-1:0]   r_wr_data;
    logic [WORD_SIZE-1:0]   r_rd_data;
    logic                   r_rd_done;
    logic                   r_wr_done;
`ifdef NODE_IO_LAST_PORT_EN
    logic                   r_last_vld;
    logic [1:0]             r_last_dir;
`endif

    logic [2:0]             w_req_src;
    logic [2:0]             w_eff_src;
    logic                   w_eff_nb;
    logic [3:0]             w_mask;
    logic [3:0]             w_hit;
    logic [1:0]             w_win;

    // Resolve the requested source/destination; LAST collapses to a concrete direction or NIL here
    // so the wait states only ever see a direction or ANY.
    always_comb begin
        w_req_src = rd_req ? rd_src : wr_dst;
        w_eff_src = w_req_src;
        if (w_req_src == SRC_LAST) begin
`ifdef NODE_IO_LAST_PORT_EN
            w_eff_src = r_last_vld ? {1'b0, r_last_dir} : SRC_NIL;
`else
            w_eff_src = SRC_NIL;
`endif
        end
        w_eff_nb = (w_eff_src == SRC_ANY) || !w_eff_src[2];
    end

    // Link mask for the latched target: one bit for a direction, all four for ANY.
    always_comb begin
        w_mask = (r_src == SRC_ANY) ? 4'b1111 : (4'b0001 << r_src[1:0]);
    end

    assign in_ready  = (r_state == RD_WAIT) ? w_mask : 4'b0000;
    assign out_valid = (r_state == WR_WAIT) ? w_mask : 4'b0000;
    assign out_data  = r_wr_data;
    assign rd_data   = r_rd_data;
    assign rd_done   = r_rd_done;
    assign wr_done   = r_wr_done;

    // Handshaking links this cycle and the winner among them, LEFT > RIGHT > UP > DOWN.
    always_comb begin
        w_hit = (r_state == RD_WAIT) ? (in_valid & in_ready) : (out_valid & out_ready);
        if (w_hit[LEFT])       w_win = LEFT;
        else if (w_hit[RIGHT]) w_win = RIGHT;
        else if (w_hit[UP])    w_win = UP;
        else                   w_win = DOWN;
    end

    // Operation FSM with registered done pulses and data registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= IDLE;
            r_src     <= SRC_NIL;
            r_wr_data <= '0;
            r_rd_data <= '0;
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
`ifdef NODE_IO_LAST_PORT_EN
            r_last_vld <= 1'b0;
            r_last_dir <= 2'd0;
`endif
        end else begin
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        r_src <= w_eff_src;
                        if (w_eff_nb) begin
                            r_state <= rd_req ? RD_WAIT : WR_WAIT;
                            if (!rd_req) r_wr_data <= wr_data;
                        end else begin
                            // NIL/ACC: reads return zero, writes are dropped.
                            r_state <= DONE;
                            if (rd_req) begin
                                r_rd_data <= '0;
                                r_rd_done <= 1'b1;
                            end else begin
                                r_wr_done <= 1'b1;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    // A withdrawn request aborts silently, even if a link is offering.
                    if (!rd_req) begin
                        r_state <= IDLE;
                    end else if (|w_hit) begin
                        r_rd_data <= in_data[w_win];
                        r_rd_done <= 1'b1;
                        r_state   <= DONE;
`ifdef NODE_IO_LAST_PORT_EN
                        if (r_src == SRC_ANY) begin
                            r_last_vld <= 1'b1;
                            r_last_dir <= w_win;
                        end
`endif
                    end
                end
                WR_WAIT: begin
                    if (!wr_req) begin
                        r_state <= IDLE;
                    end else if (|w_hit) begin
                        r_wr_done <= 1'b1;
                        r_state   <= DONE;
`ifdef NODE_IO_LAST_PORT_EN
                        if (r_src == SRC_ANY) begin
                            r_last_vld <= 1'b1;
                            r_last_dir <= w_win;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_node_io.sv
// Bench for node_io: table vectors, hand sequences for abort/reset/LAST, then random ops vs a model.
module tb_node_io;
    localparam int W = 11;
`ifdef NODE_IO_LAST_PORT_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif
    localparam logic [2:0] S_UP = 3'd0, S_DOWN = 3'd1, S_LEFT = 3'd2, S_RIGHT = 3'd3;
    localparam logic [2:0] S_ANY = 3'd4, S_NIL = 3'd5, S_ACC = 3'd6, S_LAST = 3'd7;

    logic              CLK, nRST;
    logic              rd_req, wr_req, rd_done, wr_done;
    logic [2:0]        rd_src, wr_dst;
    logic [W-1:0]      rd_data, wr_data, out_data;
    logic [3:0]        in_valid, in_ready, out_valid, out_ready;
    logic [3:0][W-1:0] in_data;

    node_io #(.WORD_SIZE(W)) dut (
        .CLK(CLK), .nRST(nRST),
        .rd_req(rd_req), .rd_src(rd_src), .rd_data(rd_data), .rd_done(rd_done),
        .wr_req(wr_req), .wr_dst(wr_dst), .wr_data(wr_data), .wr_done(wr_done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        bit                is_rd;
        logic [2:0]        src;
        logic [W-1:0]      wdat;
        logic [3:0]        vr;        // in_valid (read) or out_ready (write) offered after the blocked cycles
        int                dly;       // cycles spent blocked in the wait state
        logic [3:0][W-1:0] nd;        // neighbour words {RIGHT, LEFT, DOWN, UP}
        logic [3:0]        exp_mask;  // expected in_ready/out_valid; 0 means immediate done
        logic [W-1:0]      exp_rd;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         m_last_vld = 1'b0;
    logic [1:0] m_last_dir = 2'd0;
    vec_t       tbl[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Priority search over links in LEFT, RIGHT, UP, DOWN order.
    function automatic int first_dir(input logic [3:0] m);
        int order[4] = '{2, 3, 0, 1};
        for (int i = 0; i < 4; i++) if (m[order[i]]) return order[i];
        return -1;
    endfunction

    // Which links a request for src should engage, given what the model remembers.
    function automatic logic [3:0] mask_of(input logic [2:0] src);
        logic [2:0] e = src;
        if (src == S_LAST) e = (LAST_EN && m_last_vld) ? {1'b0, m_last_dir} : S_NIL;
        if (e == S_ANY) return 4'b1111;
        if (e < 3'd4)   return 4'b0001 << e;
        return 4'b0000;
    endfunction

    task automatic check_wait(input vec_t v, input string nm);
        check({nm, " in_ready"},  32'(in_ready),  32'(v.is_rd ? v.exp_mask : 4'b0));
        check({nm, " out_valid"}, 32'(out_valid), 32'(v.is_rd ? 4'b0 : v.exp_mask));
        check({nm, " no done"},   32'({rd_done, wr_done}), 32'd0);
        if (!v.is_rd) check({nm, " out_data"}, 32'(out_data), 32'(v.wdat));
    endtask

    // Runs one operation starting at a negedge with the DUT idle; ends at a negedge, idle again.
    task automatic run_op(input vec_t v, input string nm);
        rd_req = v.is_rd; wr_req = !v.is_rd;
        rd_src = v.src;   wr_dst = v.src;  wr_data = v.wdat;
        in_data = v.nd;   in_valid = 4'b0; out_ready = 4'b0;
        #1;
        check({nm, " idle hs"}, 32'({in_ready, out_valid}), 32'd0);
        @(negedge CLK);
        if (v.exp_mask != 4'b0) begin
            for (int k = 0; k < v.dly; k++) begin
                check_wait(v, nm);
                if (v.is_rd) in_valid  = 4'($urandom) & ~v.exp_mask;
                else         out_ready = 4'($urandom) & ~v.exp_mask;
                @(negedge CLK);
            end
            check_wait(v, nm);
            in_valid = 4'b0; out_ready = 4'b0;
            if (v.is_rd) in_valid = v.vr; else out_ready = v.vr;
            @(negedge CLK);
        end
        check({nm, " done"}, 32'({rd_done, wr_done}), v.is_rd ? 32'd2 : 32'd1);
        if (v.is_rd) check({nm, " rd_data"}, 32'(rd_data), 32'(v.exp_rd));
        check({nm, " done hs"}, 32'({in_ready, out_valid}), 32'd0);
        rd_req = 1'b0; wr_req = 1'b0; in_valid = 4'b0; out_ready = 4'b0;
        if (v.exp_mask == 4'b1111) begin
            m_last_vld = 1'b1;
            m_last_dir = 2'(first_dir(v.vr));
        end
        @(negedge CLK);
        check({nm, " pulse end"}, 32'({rd_done, wr_done}), 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [3:0] m;
        rd_req = 0; wr_req = 0; rd_src = 0; wr_dst = 0; wr_data = 0;
        in_valid = 0; in_data = '0; out_ready = 0;
        nRST = 1'b0;
        #1;
        check("reset outputs", 32'({rd_done, wr_done, in_ready, out_valid}), 32'd0);
        check("reset data", 32'({rd_data, out_data}), 32'd0);
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // LAST straight out of reset behaves as NIL with or without the feature.
        run_op('{1'b1, S_LAST, 11'h0, 4'b1111, 0, {11'h7, 11'h6, 11'h5, 11'h4}, 4'b0, 11'h0}, "last_rst_rd");
        run_op('{1'b0, S_LAST, 11'h3AB, 4'b1111, 0, '0, 4'b0, 11'h0}, "last_rst_wr");

        tbl[0]  = '{1'b1, S_NIL,   11'h0,   4'b1111, 0, {11'h9, 11'h8, 11'h7, 11'h6}, 4'b0000, 11'h0};
        tbl[1]  = '{1'b0, S_NIL,   11'h2F0, 4'b1111, 0, '0, 4'b0000, 11'h0};
        tbl[2]  = '{1'b1, S_ACC,   11'h0,   4'b1111, 0, {11'h9, 11'h8, 11'h7, 11'h6}, 4'b0000, 11'h0};
        tbl[3]  = '{1'b1, S_LEFT,  11'h0,   4'b0100, 3, {11'h77, 11'h05, 11'h66, 11'h55}, 4'b0100, 11'h05};
        tbl[4]  = '{1'b1, S_ANY,   11'h0,   4'b1101, 0, {11'h3, 11'h2, 11'h7FF, 11'h1}, 4'b1111, 11'h2};
        tbl[5]  = '{1'b0, S_ANY,   11'h7FF, 4'b1001, 0, '0, 4'b1111, 11'h0};
        tbl[6]  = '{1'b1, S_UP,    11'h0,   4'b1111, 1, {11'h1, 11'h2, 11'h3, 11'h123}, 4'b0001, 11'h123};
        tbl[7]  = '{1'b1, S_DOWN,  11'h0,   4'b1111, 0, {11'h1, 11'h2, 11'h456, 11'h3}, 4'b0010, 11'h456};
        tbl[8]  = '{1'b1, S_RIGHT, 11'h0,   4'b1000, 2, {11'h6DB, 11'h2, 11'h3, 11'h4}, 4'b1000, 11'h6DB};
        tbl[9]  = '{1'b0, S_DOWN,  11'h155, 4'b1111, 1, '0, 4'b0010, 11'h0};
        tbl[10] = '{1'b1, S_ANY,   11'h0,   4'b0011, 0, {11'h1, 11'h2, 11'h111, 11'h0AB}, 4'b1111, 11'h0AB};
        tbl[11] = '{1'b1, S_ANY,   11'h0,   4'b0010, 1, {11'h1, 11'h2, 11'h111, 11'h0AB}, 4'b1111, 11'h111};
        tbl[12] = '{1'b0, S_UP,    11'h000, 4'b0001, 2, '0, 4'b0001, 11'h0};
        for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // After an ANY read won by LEFT, LAST targets LEFT (or NIL without the feature).
        run_op(tbl[4], "any_left");
        v = '{1'b1, S_LAST, 11'h0, 4'b1111, 1, {11'h44, 11'h33, 11'h22, 11'h11},
              LAST_EN ? 4'b0100 : 4'b0000, LAST_EN ? 11'h33 : 11'h0};
        run_op(v, "last_left");

        // Withdrawn ANY read: no done, handshake drops, LAST unchanged.
        rd_req = 1'b1; rd_src = S_ANY; in_valid = 4'b0;
        @(negedge CLK);
        check("abort in_ready", 32'(in_ready), 32'hF);
        rd_req = 1'b0;
        @(negedge CLK);
        check("abort idle", 32'({in_ready, rd_done, wr_done}), 32'd0);
        @(negedge CLK);
        check("abort no done", 32'({rd_done, wr_done}), 32'd0);
        run_op(v, "last_after_abort");

        // Reset in the middle of a blocked write.
        wr_req = 1'b1; wr_dst = S_RIGHT; wr_data = 11'h2AA; out_ready = 4'b0;
        @(negedge CLK);
        check("wrwait out_valid", 32'(out_valid), 32'h8);
        check("wrwait out_data", 32'(out_data), 32'h2AA);
        #2 nRST = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst out_data", 32'(out_data), 32'h0);
        wr_req = 1'b0; m_last_vld = 1'b0;
        @(negedge CLK);
        check("rst no wr_done", 32'(wr_done), 32'h0);
        nRST = 1'b1;
        @(negedge CLK);
        check("post rst idle", 32'({out_valid, in_ready, wr_done}), 32'd0);
        run_op('{1'b1, S_LAST, 11'h0, 4'b1111, 0, {11'h4, 11'h3, 11'h2, 11'h1}, 4'b0, 11'h0}, "post_rst_last");

        // Random operations against the model.
        for (int n = 0; n < 60; n++) begin
            v.is_rd = bit'($urandom_range(0, 1));
            v.src   = 3'($urandom_range(0, 7));
            v.wdat  = W'($urandom);
            v.dly   = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) v.nd[i] = W'($urandom);
            m = mask_of(v.src);
            v.vr = 4'($urandom_range(0, 15));
            if ((v.vr & m) == 4'b0)
                v.vr = v.vr | ((m == 4'b1111) ? (4'b0001 << $urandom_range(0, 3)) : m);
            v.exp_mask = m;
            v.exp_rd   = (m == 4'b0) ? '0 : v.nd[first_dir(v.vr & m)];
            run_op(v, $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
